fact_result_fifo: RTL
=====================

Name: fact_result_fifo

Overview:
- Parametrised result-capture buffer for the factorial accelerator.
- Each accepted load pulse stores one {Err, Done, D} tuple. Older generations held only a single result and flag set.
- Queues up to DEPTH completed results so the bus side can drain them asynchronously to computation.
- Adds sticky overflow/underflow flags, occupancy count and a threshold interrupt. Sits between the factorial datapath/FSM and the memory-mapped register interface.

Parameters:
- W, 32, result data width.
- DEPTH, 4, number of entries; power of two, >= 2.
- IRQ_THRESH, 1, occupancy at or above which Irq asserts; 1..DEPTH.
- CW, $clog2(DEPTH)+1, count width (derived, not overridden).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- D  in  W  result data from datapath.
- Done  in  1  done status accompanying D.
- Err  in  1  error status accompanying D.
- Load  in  1  push request (single-cycle pulse from FSM).
- Pop  in  1  pop request from bus side.
- ClrFlags  in  1  synchronous clear of Ovf and Udf.
- Q  out  W  head-entry data.
- ResDone  out  1  head-entry Done bit.
- ResErr  out  1  head-entry Err bit.
- Empty  out  1  no entries.
- Full  out  1  Count == DEPTH.
- Count  out  CW  occupancy 0..DEPTH.
- Ovf  out  1  sticky: a push was dropped.
- Udf  out  1  sticky: a pop hit an empty buffer.
- Irq  out  1  Count >= IRQ_THRESH.

Behaviour:
- Reset: asynchronous, active-low (Rst_n=0). Clears wr_ptr, rd_ptr, Count, Ovf, Udf and Irq, and sets Empty=1.
  - Storage array need not be cleared.
  - Q, ResDone and ResErr read 0 while Empty.
  - Reset mid-operation discards all queued entries immediately, without waiting for a clock.
- Read side is first-word-fall-through:
  - Q/ResDone/ResErr are combinational from mem[rd_ptr], gated to 0 when Empty.
  - A pushed entry is visible on Q the cycle after the Load edge. Push-to-read latency is 1.
- Push (Load=1, Full=0): mem[wr_ptr] <= {Err, Done, D}; wr_ptr increments modulo DEPTH (natural wrap); Count+1.
- Pop (Pop=1, Empty=0): rd_ptr increments modulo DEPTH; Count-1; the next head appears the following cycle.
- Simultaneous Load and Pop:
  - Non-empty, non-full: both occur; Count unchanged.
  - Full: pop frees a slot, so the push is accepted; Count stays DEPTH; Ovf not set.
  - Empty: push accepted, pop counts as underflow (Udf<=1); Count becomes 1. The new entry is not popped in the same cycle.
- Load while Full without Pop: data dropped, pointers/Count unchanged, Ovf<=1.
- Pop while Empty: ignored, Udf<=1.
- Ovf/Udf remain set until ClrFlags=1 or reset. If ClrFlags and a new overflow/underflow event occur in the same cycle, the set wins.
- Irq is registered: Irq <= (Count_next >= IRQ_THRESH). It therefore changes on the same edge as Count.
- Empty = (Count==0); Full = (Count==DEPTH); both are combinational from the Count register.
- Load and Pop are level-sampled each cycle. The producer FSM is responsible for one-cycle pulses.

Decomposition:
- Package fact_pkg holds:
  - ENTRY_W = W+2 and field-offset constants (ERR_BIT = W+1, DONE_BIT = W).
  - Default DEPTH/IRQ_THRESH constants shared with the register-map decoder.
- One natural sub-module, fact_sticky_flag: set/clear sticky bit with set priority, async active-low reset. Instantiated twice (Ovf, Udf).
- Storage plus pointer logic stays in the top module.

Test Plan:
- Reset/idle: drive Rst_n=0 mid-stream with 2 entries queued -> immediately Count=0, Empty=1, Q=0, Ovf=Udf=Irq=0.
- Fill/drain order (DEPTH=4): push D=1,2,6,24 with Done=1, then set Err=1 on 24 -> Full=1, Count=4. Four pops yield Q=1,2,6,24 in order, with ResErr=1 only on 24, then Empty=1.
- Overflow: at Full, Load D=120 without Pop -> Ovf=1, Count=4, 120 never appears. ClrFlags -> Ovf=0.
- Full push+pop: at Full, Load D=720 with Pop -> Count=4, Ovf=0; after draining, 720 is last out.
- Underflow and empty push+pop: Pop on empty -> Udf=1, Count=0. Then Load D=5 with Pop on empty -> Count=1, Q=5, Udf=1.
- Wrap and Irq (IRQ_THRESH=3): ten push/pop cycles so pointers wrap twice; data order preserved. Irq rises on the edge Count reaches 3 and falls on the edge it drops to 2.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared constants for the factorial accelerator result path.
// Entry layout is {Err, Done, D}; defaults are also used by the register map.
package fact_pkg;

  localparam int DEF_W          = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_IRQ_THRESH = 1;

  function automatic int entry_w(input int w);
    return w + 2;
  endfunction

  function automatic int err_bit(input int w);
    return w + 1;
  endfunction

  function automatic int done_bit(input int w);
    return w;
  endfunction

endpackage

// File: rtl/fact_sticky_flag.sv
// Sticky status bit: set has priority over clear.
// Asynchronous active-low reset.
module fact_sticky_flag (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Set,
  input  logic Clr,
  output logic Q
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)   Q <= 1'b0;
    else if (Set) Q <= 1'b1;
    else if (Clr) Q <= 1'b0;
  end

endmodule

// File: rtl/fact_result_fifo.sv
// First-word-fall-through result queue for the factorial accelerator,
// with sticky overflow/underflow flags and an occupancy interrupt.
module fact_result_fifo
  import fact_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IRQ_THRESH = DEF_IRQ_THRESH,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [W-1:0]  D,
  input  logic          Done,
  input  logic          Err,
  input  logic          Load,
  input  logic          Pop,
  input  logic          ClrFlags,
  output logic [W-1:0]  Q,
  output logic          ResDone,
  output logic          ResErr,
  output logic          Empty,
  output logic          Full,
  output logic [CW-1:0] Count,
  output logic          Ovf,
  output logic          Udf,
  output logic          Irq
);

  localparam int ENTRY_W = entry_w(W);
  localparam int ERR_B   = err_bit(W);
  localparam int DONE_B  = done_bit(W);
  localparam int AW      = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_next;
  logic [ENTRY_W-1:0] head;
  logic               push_ok;
  logic               pop_ok;
  logic               ovf_set;
  logic               udf_set;

  assign Empty = (Count == '0);
  assign Full  = (Count == CW'(DEPTH));

  // A pop at Full frees the slot the push needs in the same cycle
  assign pop_ok  = Pop && !Empty;
  assign push_ok = Load && (!Full || Pop);
  assign ovf_set = Load && Full && !Pop;
  assign udf_set = Pop && Empty;

  always_comb begin
    count_next = Count;
    if (push_ok && !pop_ok) count_next = Count + 1'b1;
    if (!push_ok && pop_ok) count_next = Count - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= {Err, Done, D};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Irq    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      Count <= count_next;
      Irq   <= (count_next >= CW'(IRQ_THRESH));
    end
  end

  assign head    = Empty ? '0 : mem[rd_ptr];
  assign Q       = head[W-1:0];
  assign ResDone = head[DONE_B];
  assign ResErr  = head[ERR_B];

  fact_sticky_flag u_ovf (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Set   (ovf_set),
    .Clr   (ClrFlags),
    .Q     (Ovf)
  );

  fact_sticky_flag u_udf (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Set   (udf_set),
    .Clr   (ClrFlags),
    .Q     (Udf)
  );

endmodule
